// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage: data/address widths, stall encoding
// and the register number that means "no destination".
package wb_regfile_pkg;

  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;

  localparam logic [RegBusW-1:0]     ZeroWord   = '0;
  localparam logic                   ZeroBit    = 1'b0;
  localparam logic                   Stop       = 1'b1;
  localparam logic                   NoStop     = 1'b0;
  localparam logic [RegAddrBusW-1:0] NopRegAddr = 5'b00000;

  // Bit of the pipeline stall vector that belongs to the writeback stage.
  localparam int WbStallBit = 5;

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair: both halves commit together on the clock edge, and a
// committing write is bypassed to the outputs in the same cycle.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBusW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              wr;

  assign wr = commit && we;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr) begin
      hi_q <= hi_in;
      lo_q <= lo_in;
    end
  end

  // Reset forces zero even before the first reset edge has cleared storage.
  always_comb begin
    hi = hi_q;
    lo = lo_q;
    if (reset) begin
      hi = '0;
      lo = '0;
    end else if (wr) begin
      hi = hi_in;
      lo = lo_in;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: GPR file + HI/LO commit with same-cycle bypass to the read
// ports, and a one-cycle-late commit trace. A WB stall blocks commit and bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W  = RegBusW,
  parameter int ADDR_W  = RegAddrBusW,
  parameter int REG_NUM = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        stall,
  input  logic [DATA_W-1:0] i_d1,
  input  logic [DATA_W-1:0] i_d2,
  input  logic [ADDR_W-1:0] i_rn,
  input  logic              i_write_regfile,
  input  logic              i_mem_to_regfile,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  input  logic              i_write_hilo,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_ra1,
  output logic [DATA_W-1:0] o_rd1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd2,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_trace_we,
  output logic [ADDR_W-1:0] o_trace_rn,
  output logic [DATA_W-1:0] o_trace_data
);

  logic [DATA_W-1:0] gpr [REG_NUM];
  logic [DATA_W-1:0] wb_data;
  logic              commit;
  logic              byp_en;
  logic              gpr_we;
  logic              unused_stall;

  // Only the WB stage's stall bit matters here.
  assign unused_stall = ^stall[4:0];

  assign wb_data = i_mem_to_regfile ? i_d2 : i_d1;
  assign commit  = !reset && (stall[WbStallBit] == NoStop);
  assign byp_en  = commit && i_write_regfile;
  assign gpr_we  = byp_en && (i_rn != NopRegAddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr[i_rn] <= wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst,
    input logic              re,
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              bypass,
    input logic [ADDR_W-1:0] rn,
    input logic [DATA_W-1:0] data
  );
    if (rst || !re || ra == NopRegAddr) begin
      return '0;
    end else if (bypass && ra == rn) begin
      return data;
    end
    return stored;
  endfunction

  always_comb begin
    o_rd1 = read_port(reset, i_re1, i_ra1, gpr[i_ra1], byp_en, i_rn, wb_data);
    o_rd2 = read_port(reset, i_re2, i_ra2, gpr[i_ra2], byp_en, i_rn, wb_data);
  end

  hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk   (clk),
    .reset (reset),
    .commit(commit),
    .we    (i_write_hilo),
    .hi_in (i_hi),
    .lo_in (i_lo),
    .hi    (o_hi),
    .lo    (o_lo)
  );

  // rn/data keep the last logged write so the debug side sees it after we drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_trace_we   <= ZeroBit;
      o_trace_rn   <= '0;
      o_trace_data <= '0;
    end else begin
      o_trace_we <= gpr_we;
      if (gpr_we) begin
        o_trace_rn   <= i_rn;
        o_trace_data <= wb_data;
      end
    end
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs. It holds the 32-entry general register file and the HI/LO register pair, and commits the writeback bundle (d1/d2, rn, write/mem-select flags, hi/lo, write_hilo) on the clock edge. It provides two combinational read ports to decode and a HI/LO read port to execute, with same-cycle writeback bypass. It also emits a registered commit trace for the debug interface.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width
REG_NUM, 32, number of GPRs (2**ADDR_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  6  pipeline stall vector; bit 5 = WB stage
i_d1  in  32  ALU/move result
i_d2  in  32  memory load data
i_rn  in  5  destination GPR
i_write_regfile  in  1  GPR write enable
i_mem_to_regfile  in  1  1: write i_d2, 0: write i_d1
i_hi  in  32  HI write value
i_lo  in  32  LO write value
i_write_hilo  in  1  HI/LO write enable
i_re1  in  1  read port 1 enable
i_ra1  in  5  read port 1 address
o_rd1  out  32  read port 1 data
i_re2  in  1  read port 2 enable
i_ra2  in  5  read port 2 address
o_rd2  out  32  read port 2 data
o_hi  out  32  current HI (bypassed)
o_lo  out  32  current LO (bypassed)
o_trace_we  out  1  registered: a GPR write committed last cycle
o_trace_rn  out  5  registered: committed register number
o_trace_data  out  32  registered: committed data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. On the reset edge, all 32 GPRs, HI, LO and trace outputs are cleared to 0.
- While reset is high: o_rd1, o_rd2, o_hi and o_lo read 0, and commits are suppressed.
- wb_data = i_mem_to_regfile ? i_d2 : i_d1, a combinational mux.
- Commit condition: commit = !reset && stall[5]==NoStop (0).
- GPR write: on a clk edge with commit && i_write_regfile && i_rn!=0, GPR[i_rn] <= wb_data. A write to r0 is discarded, and r0 always reads 0.
- HI/LO write: on a clk edge with commit && i_write_hilo, HI <= i_hi and LO <= i_lo. Both are written together and are never split.
- Read port n, combinational, in priority order:
  - reset → 0
  - !i_ren → 0
  - i_ran==0 → 0
  - i_ran==i_rn && i_write_regfile && commit → wb_data (bypass)
  - otherwise GPR[i_ran]
- HI/LO read: if commit && i_write_hilo, o_hi/o_lo = i_hi/i_lo (bypass); otherwise the stored HI/LO.
- When stall[5]==Stop, nothing is written and no bypass is applied. The WB bundle must be held stable by upstream.
- Trace, updated each edge:
  - o_trace_we <= commit && i_write_regfile && i_rn!=0
  - o_trace_rn <= i_rn and o_trace_data <= wb_data when logging; otherwise both hold their previous values.
- Latency: write becomes visible in storage one edge after presentation, and is visible via bypass in the same cycle.
- Both read ports may address the same register, and both may hit the bypass simultaneously.
- Reset mid-stream: a write presented in the same cycle as reset is lost.

Decomposition:
- Shared global define header: ZeroWord, ZeroBit, Stop/NoStop, RegAddrBus/RegBus widths, NOP register address 5'b00000.
- One natural sub-module, hilo_reg: the HI/LO pair with write enable and bypass. The GPR array and read ports stay in wb_regfile.

Test Plan:
1. Reset, then read r1..r31 on both ports → all 0. Write hilo=(5,6) while reset=1 → o_hi/o_lo stay 0 after reset drops.
2. i_rn=8, i_d1=0x12345678, i_write_regfile=1, i_mem_to_regfile=0, i_ra1=8 → o_rd1=0x12345678 in the same cycle (bypass). Next cycle with the write deasserted → still 0x12345678. Trace shows we=1, rn=8.
3. i_mem_to_regfile=1, i_d1=0xAAAA0000, i_d2=0xDEADBEEF, i_rn=3 → GPR3=0xDEADBEEF. Write i_rn=0 with 0xFFFFFFFF → reading r0 returns 0 and trace we=0.
4. stall=6'b100000 with a write to r5=0x55 → r5 stays at its old value, no bypass, trace we=0. Release stall → r5=0x55.
5. i_write_hilo=1, i_hi=0x1, i_lo=0x2 → o_hi=1/o_lo=2 the same cycle. Then i_hi=0x9 with write disabled → o_hi stays 1.
6. Both ports read r7 while r7 is being written with 0x77 → o_rd1=o_rd2=0x77. Then i_re2=0 → o_rd2=0.
